// File: rtl/ncca_pkg.sv
// ncca_pkg: mode encodings, digit width and PP exactness selection shared by the approximate multiplier
package ncca_pkg;
  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_SPLIT  = 2'd1;
  localparam logic [1:0] MODE_APPROX = 2'd2;
  localparam int DIGIT = 4;
  function automatic logic pp_is_exact(input logic [1:0] mode, input int i, input int j, input int exact_rank);
    return mode == MODE_SPLIT ? (i + j >= exact_rank) : mode != MODE_APPROX;
  endfunction
endpackage

// File: rtl/ncca_nib_mul.sv
// ncca_nib_mul: 4x4 -> 8 digit multiplier, optionally zeroing the TRUNC low bits
module ncca_nib_mul #(
  parameter int TRUNC = 2
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       exact,
  output logic [7:0] p
);
  localparam logic [7:0] KEEP = 8'hFF << TRUNC;
  logic [7:0] full;
  assign full = 8'(a) * 8'(b);
  assign p = exact ? full : full & KEEP;
endmodule

// File: rtl/ncca_pipe_mul.sv
// ncca_pipe_mul: 3-stage pipelined WxW approximate multiplier built from per-digit partial products
module ncca_pipe_mul
  import ncca_pkg::*;
#(
  parameter int W          = 8,
  parameter int TRUNC      = 2,
  parameter int EXACT_RANK = 2 * (W / 4) - 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic [1:0]     out_mode
);
  localparam int N = W / DIGIT;
  logic           adv, v1, v2, v3;
  logic [W-1:0]   a1, b1;
  logic [1:0]     m1, m2;
  logic [7:0]     pp_c [N*N];
  logic [7:0]     pp   [N*N];
  logic [2*W-1:0] sum;
  // one global enable: the whole pipe moves or the whole pipe holds
  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  for (genvar i = 0; i < N; i++) begin : g_a
    for (genvar j = 0; j < N; j++) begin : g_b
      ncca_nib_mul #(.TRUNC(TRUNC)) u_nib (
        .a    (a1[DIGIT*i +: DIGIT]),
        .b    (b1[DIGIT*j +: DIGIT]),
        .exact(pp_is_exact(m1, i, j, EXACT_RANK)),
        .p    (pp_c[i*N+j])
      );
    end
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < N*N; k++) sum = sum + ((2*W)'(pp[k]) << (DIGIT * (k / N + k % N)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      m1       <= MODE_EXACT;
      m2       <= MODE_EXACT;
      pp       <= '{default: '0};
      out_prod <= '0;
      out_mode <= MODE_EXACT;
    end else if (adv) begin
      v1       <= in_valid;
      a1       <= in_a;
      b1       <= in_b;
      m1       <= in_mode == 2'd3 ? MODE_EXACT : in_mode;
      v2       <= v1;
      pp       <= pp_c;
      m2       <= m1;
      v3       <= v2;
      out_prod <= sum;
      out_mode <= m2;
    end
  end
endmodule
